// File: rtl/choreo_sequencer.sv
// Choreography step sequencer: walks a programmable table of (pattern, speed, duration)
// entries on beat ticks and drives the LED pattern generator controls.
`timescale 1ns/1ps
module choreo_sequencer #(
    parameter int STEPS  = 8,
    parameter int ADDR_W = 3,
    parameter int DUR_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DUR_W+3:0]  cfg_wdata,
    input  logic [ADDR_W-1:0] last_step,
    input  logic              loop_en,
    input  logic              start,
    input  logic              stop,
    input  logic              hold_req,
    input  logic              beat_tick,
    output logic [2:0]        gen_pat_sel,
    output logic              gen_speed_sel,
    output logic              gen_pause,
    output logic              gen_ena,
    output logic [ADDR_W-1:0] step_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, HOLD, DONE} state_t;

    localparam logic [2:0] PAT_OFF = 3'b111;

    state_t              state;
    logic [DUR_W+3:0]    table_q [STEPS];
    logic [DUR_W:0]      beat_cnt;
    logic [ADDR_W-1:0]   last_q;
    logic                loop_q;
    logic [DUR_W+3:0]    entry;
    logic [DUR_W:0]      dur_beats;
    logic                stop_act;

    assign entry     = table_q[step_idx];
    // A zero duration field stands for the full 2^DUR_W beats.
    assign dur_beats = (entry[DUR_W-1:0] == '0) ? ((DUR_W+1)'(1) << DUR_W)
                                                : {1'b0, entry[DUR_W-1:0]};
    assign stop_act  = stop && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            gen_pat_sel   <= PAT_OFF;
            gen_speed_sel <= 1'b0;
            gen_pause     <= 1'b0;
            gen_ena       <= 1'b0;
            step_idx      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            beat_cnt      <= '0;
            last_q        <= '0;
            loop_q        <= 1'b0;
            for (int i = 0; i < STEPS; i++) table_q[i] <= '0;
        end else begin
            gen_ena <= 1'b0;
            done    <= 1'b0;
            if (cfg_we && (state == IDLE || state == DONE))
                table_q[cfg_addr] <= cfg_wdata;

            if (stop_act) begin
                state       <= IDLE;
                gen_pat_sel <= PAT_OFF;
                gen_ena     <= 1'b1;
                gen_pause   <= 1'b0;
                step_idx    <= '0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            step_idx <= '0;
                            last_q   <= last_step;
                            loop_q   <= loop_en;
                            busy     <= 1'b1;
                            state    <= LOAD;
                        end
                    end
                    LOAD: begin
                        gen_pat_sel   <= entry[DUR_W+3:DUR_W+1];
                        gen_speed_sel <= entry[DUR_W];
                        gen_ena       <= 1'b1;
                        gen_pause     <= 1'b0;
                        beat_cnt      <= dur_beats;
                        state         <= RUN;
                    end
                    RUN: begin
                        if (hold_req) begin
                            gen_pause <= 1'b1;
                            state     <= HOLD;
                        end else if (beat_tick) begin
                            if (beat_cnt == (DUR_W+1)'(1)) begin
                                if (step_idx != last_q) begin
                                    step_idx <= step_idx + ADDR_W'(1);
                                    state    <= LOAD;
                                end else if (loop_q) begin
                                    step_idx <= '0;
                                    state    <= LOAD;
                                end else begin
                                    gen_pat_sel <= PAT_OFF;
                                    gen_ena     <= 1'b1;
                                    done        <= 1'b1;
                                    busy        <= 1'b0;
                                    state       <= DONE;
                                end
                            end else begin
                                beat_cnt <= beat_cnt - (DUR_W+1)'(1);
                            end
                        end
                    end
                    HOLD: begin
                        if (!hold_req) begin
                            gen_pause <= 1'b0;
                            state     <= RUN;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
